// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
// master = datapath side, slave = register file.
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             wen;
  logic [AW-1:0]    selRd;
  logic [WIDTH-1:0] rd;
  logic [AW-1:0]    selRs;
  logic [AW-1:0]    selRt;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             resv;
  logic [AW-1:0]    selResv;
  logic             rsBusy;
  logic             rtBusy;
  logic             clr;
  logic             clrBusy;

  modport master (
    output wen, selRd, rd, selRs, selRt, resv, selResv, clr,
    input  rs, rt, rsBusy, rtBusy, clrBusy
  );

  modport slave (
    input  wen, selRd, rd, selRs, selRt, resv, selResv, clr,
    output rs, rt, rsBusy, rtBusy, clrBusy
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file, 1 write / 2 combinational read ports, pending-write scoreboard
// and a one-register-per-cycle bulk-clear engine; writes land 1 cycle later.
module regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic w_idle;
  logic w_wr;
  logic w_rsv;
  logic w_zs;
  logic w_zt;
  logic w_byp_s;
  logic w_byp_t;

  assign w_idle = (r_state == IDLE);
  assign w_wr   = w_idle && bus.wen  && !((ZERO_R0 != 0) && (bus.selRd == '0));
  assign w_rsv  = w_idle && bus.resv && !((ZERO_R0 != 0) && (bus.selResv == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.clr) w_next = CLEAR;
      CLEAR:   if (r_cnt == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counter rests at 0 in IDLE, so the wrap out of CLEAR lands exactly there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_cnt <= '0;
    else if (w_idle)   r_cnt <= '0;
    else               r_cnt <= r_cnt + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else if (w_idle) begin
      if (w_wr) begin
        r_mem[bus.selRd]  <= bus.rd;
        r_pend[bus.selRd] <= 1'b0;
      end
      // Reserve is applied last: a new producer outranks the retiring one.
      if (w_rsv) r_pend[bus.selResv] <= 1'b1;
    end else begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
    end
  end

  assign w_zs    = (ZERO_R0 != 0) && (bus.selRs == '0);
  assign w_zt    = (ZERO_R0 != 0) && (bus.selRt == '0);
  assign w_byp_s = (BYPASS != 0) && bus.wen && w_idle && (bus.selRd == bus.selRs);
  assign w_byp_t = (BYPASS != 0) && bus.wen && w_idle && (bus.selRd == bus.selRt);

  assign bus.rs      = w_zs ? '0 : (w_byp_s ? bus.rd : r_mem[bus.selRs]);
  assign bus.rt      = w_zt ? '0 : (w_byp_t ? bus.rd : r_mem[bus.selRt]);
  assign bus.rsBusy  = !w_zs && r_pend[bus.selRs];
  assign bus.rtBusy  = !w_zt && r_pend[bus.selRt];
  assign bus.clrBusy = !w_idle;
endmodule
